icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 152 +++++++++++++++
 tb/tb_icache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped, read-only instruction cache.
//
// One 128-bit line per set; a miss fetches the whole line from backing memory
// and then answers the fetch from the freshly written line.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   inst_addr_i [31:0]  CPU fetch byte address (bits [1:0] ignored)
//   inst_read_i         CPU fetch request, held until inst_resp_o
//   inst_rdata_o[31:0]  fetched word, zero unless inst_resp_o
//   inst_resp_o         one-cycle completion pulse
//   inst_flush_i        one-cycle pulse, invalidates every line
//   pmem_address_o      line-aligned fill address, zero unless pmem_read_o
//   pmem_read_o         fill request, held until pmem_resp_i
//   pmem_rdata_i[127:0] fill line, word k at [32k+31:32k]
//   pmem_resp_i         one-cycle fill completion
//
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit_count_o and
// miss_count_o (32 bits each), cleared by reset only.
// ---------------------------------------------------------------------------
module icache #(
  parameter int unsigned NUM_SETS = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  inst_addr_i,
  input  logic         inst_read_i,
  output logic [31:0]  inst_rdata_o,
  output logic         inst_resp_o,
  input  logic         inst_flush_i,
  output logic [31:0]  pmem_address_o,
  output logic         pmem_read_o,
  input  logic [127:0] pmem_rdata_i,
  input  logic         pmem_resp_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_count_o,
  output logic [31:0]  miss_count_o
`endif
);

  localparam int unsigned IDX_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_HIT, S_FILL} state_e;

  state_e state_q, state_d;

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  // A flush seen earlier in the current fill; the line must land invalid.
  logic                flushed_q, flushed_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       off;
  logic [127:0]     line;
  logic             lookup_hit;
  logic             fill_done;
  logic             unused_addr;

  assign idx         = inst_addr_i[4 +: IDX_W];
  assign tag         = inst_addr_i[31:4+IDX_W];
  assign off         = inst_addr_i[3:2];
  assign unused_addr = ^inst_addr_i[1:0];
  assign line        = data_q[idx];
  // Lookup always sees the pre-flush valid bits of this cycle.
  assign lookup_hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_done   = (state_q == S_FILL) && pmem_resp_i;

  // Next state and outputs.
  always_comb begin
    state_d        = state_q;
    inst_resp_o    = 1'b0;
    inst_rdata_o   = '0;
    pmem_read_o    = 1'b0;
    pmem_address_o = '0;
    case (state_q)
      S_IDLE: begin
        if (inst_read_i) state_d = lookup_hit ? S_HIT : S_FILL;
      end
      S_HIT: begin
        inst_resp_o = 1'b1;
        case (off)
          2'd0:    inst_rdata_o = line[31:0];
          2'd1:    inst_rdata_o = line[63:32];
          2'd2:    inst_rdata_o = line[95:64];
          default: inst_rdata_o = line[127:96];
        endcase
        state_d = S_IDLE;
      end
      S_FILL: begin
        pmem_read_o    = 1'b1;
        pmem_address_o = {inst_addr_i[31:4], 4'b0000};
        if (pmem_resp_i) state_d = S_HIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid bits: flush clears everything, a completing fill then sets its own
  // line unless a flush touched any cycle of that fill.
  always_comb begin
    valid_d   = inst_flush_i ? '0 : valid_q;
    flushed_d = 1'b0;
    if (fill_done) valid_d[idx] = !(flushed_q || inst_flush_i);
    if (state_q == S_FILL && !pmem_resp_i) flushed_d = flushed_q || inst_flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      flushed_q <= flushed_d;
    end
  end

  // Tag/data storage is not reset; reset still blocks a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (fill_done && !rst_i) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= pmem_rdata_i;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_IDLE && inst_read_i) begin
      if (lookup_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache -- directed scenarios with literal expectations, then randomized
// CPU / memory / flush / reset traffic, all checked each cycle against a
// transaction-level model of the cache held in the bench.
// ---------------------------------------------------------------------------
module tb_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  inst_addr = '0;
  logic         inst_read = 1'b0;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic         inst_flush = 1'b0;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count, miss_count;
`endif

  icache #(.NUM_SETS(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .inst_addr_i(inst_addr), .inst_read_i(inst_read),
    .inst_rdata_o(inst_rdata), .inst_resp_o(inst_resp),
    .inst_flush_i(inst_flush),
    .pmem_address_o(pmem_address), .pmem_read_o(pmem_read),
    .pmem_rdata_i(pmem_rdata), .pmem_resp_i(pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_count_o(hit_count), .miss_count_o(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // Cache contents per set plus what the fetch currently in flight is doing:
  // 0 = no fetch outstanding, 1 = answering this cycle, 2 = waiting on memory.
  bit [15:0]    mv;
  logic [23:0]  mt [16];
  logic [127:0] md [16];
  int           ph = 0;
  bit           fill_flushed;
  bit           model_ok = 1'b0;
  longint       hc = 0, mc = 0;

  always @(posedge clk) begin
    int  i;
    bit  wrote;
    logic [23:0] t;
    i = int'(inst_addr[7:4]);
    t = inst_addr[31:8];
    wrote = 1'b0;
    if (rst) begin
      ph = 0; mv = '0; fill_flushed = 1'b0; hc = 0; mc = 0; model_ok = 1'b1;
    end else begin
      case (ph)
        0: if (inst_read) begin
             if (mv[i] && mt[i] == t) begin ph = 1; hc++; end
             else begin ph = 2; mc++; fill_flushed = 1'b0; end
           end
        1: ph = 0;
        default: begin
          if (inst_flush) fill_flushed = 1'b1;
          if (pmem_resp) begin
            md[i] = pmem_rdata; mt[i] = t; wrote = 1'b1; ph = 1;
          end
        end
      endcase
      if (inst_flush) mv = '0;
      if (wrote) mv[i] = !fill_flushed;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [127:0] ln;
    logic [31:0]  e_rdata, e_paddr;
    int off;
    if (model_ok && run) begin
      ln  = md[int'(inst_addr[7:4])];
      off = int'(inst_addr[3:2]);
      e_rdata = (ph == 1) ? ln[32*off +: 32] : 32'h0;
      e_paddr = (ph == 2) ? {inst_addr[31:4], 4'h0} : 32'h0;
      chk("inst_resp", {31'b0, inst_resp}, {31'b0, ph == 1});
      chk("inst_rdata", inst_rdata, e_rdata);
      chk("pmem_read", {31'b0, pmem_read}, {31'b0, ph == 2});
      chk("pmem_address", pmem_address, e_paddr);
`ifdef ICACHE_PERF_CNT_EN
      chk("hit_count", hit_count, 32'(hc));
      chk("miss_count", miss_count, 32'(mc));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch with a 3-cycle memory latency on a miss; literal checks.
  task automatic fetch(input logic [31:0] a, input bit miss, input logic [127:0] ln,
                       input bit fl, input logic [31:0] w);
    inst_addr = a; inst_read = 1'b1;
    tick();
    if (miss) begin
      chk("d_pmem_read", {31'b0, pmem_read}, 32'd1);
      chk("d_pmem_address", pmem_address, {a[31:4], 4'h0});
      repeat (3) tick();
      pmem_rdata = ln; pmem_resp = 1'b1; inst_flush = fl;
      tick();
      pmem_resp = 1'b0; inst_flush = 1'b0;
    end else begin
      chk("d_no_pmem_read", {31'b0, pmem_read}, 32'd0);
    end
    chk("d_inst_resp", {31'b0, inst_resp}, 32'd1);
    chk("d_inst_rdata", inst_rdata, w);
    inst_read = 1'b0;
    tick();
    chk("d_resp_single", {31'b0, inst_resp}, 32'd0);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(7) != 0) a[31:8] = 24'($urandom_range(2));
    a[7:4] = 4'($urandom_range(3));
    return a;
  endfunction

  initial begin
    int mem_cnt, waitcnt;
    bit resp_seen;

    // Reset state.
    tick(); tick();
    chk("rst_inst_resp", {31'b0, inst_resp}, 32'd0);
    chk("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    rst = 1'b0;

    fetch(32'h40, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, 32'hA);
    fetch(32'h48, 1'b0, '0, 1'b0, 32'hC);
`ifdef ICACHE_PERF_CNT_EN
    chk("d_miss_count", miss_count, 32'd1);
    chk("d_hit_count", hit_count, 32'd1);
`endif
    fetch(32'h140, 1'b1, {32'h14, 32'h13, 32'h12, 32'h11}, 1'b0, 32'h11);
    fetch(32'h4C, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b0, 32'hD);
    fetch(32'h84, 1'b1, {32'h84, 32'h83, 32'h82, 32'h81}, 1'b1, 32'h82);
    fetch(32'h80, 1'b1, {32'h94, 32'h93, 32'h92, 32'h91}, 1'b0, 32'h91);

    // Reset one cycle into a fill, then a stray memory response.
    inst_addr = 32'h90; inst_read = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; inst_read = 1'b0;
    chk("abort_pmem_read", {31'b0, pmem_read}, 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    chk("abort_hit_count", hit_count, 32'd0);
    chk("abort_miss_count", miss_count, 32'd0);
`endif
    pmem_rdata = {4{32'hBAD0BAD0}}; pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("stray_inst_resp", {31'b0, inst_resp}, 32'd0);
    chk("stray_pmem_read", {31'b0, pmem_read}, 32'd0);
    fetch(32'h90, 1'b1, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 32'h1);

    // Randomized traffic.
    mem_cnt = -1; waitcnt = 0; resp_seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      // CPU side.
      if (inst_resp) begin
        resp_seen = 1'b1; waitcnt = 0;
      end else if (resp_seen) begin
        resp_seen = 1'b0;
        case ($urandom_range(3))
          0: inst_read = 1'b0;
          1: inst_read = 1'b1;
          default: begin inst_read = 1'b1; inst_addr = pick_addr(); end
        endcase
      end else if (!inst_read) begin
        if ($urandom_range(2) == 0) begin inst_read = 1'b1; inst_addr = pick_addr(); end
      end else if (++waitcnt > 40) begin
        total++; bad++;
        $display("FAIL fetch_timeout addr=%h waited=%0d limit=40", inst_addr, waitcnt);
        inst_read = 1'b0; waitcnt = 0;
      end
      // Memory side.
      pmem_resp = 1'b0;
      if (mem_cnt < 0 && pmem_read) mem_cnt = $urandom_range(3);
      if (mem_cnt == 0) begin
        pmem_resp = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_cnt = -1;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end else if (!pmem_read && $urandom_range(19) == 0) begin
        pmem_resp = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      inst_flush = ($urandom_range(15) == 0);
      rst = ($urandom_range(199) == 0);
    end
    tick();
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
